// File: rtl/apb_slave_regbank.sv
// APB slave register bank sitting behind the AHB-to-APB bridge.
// Tracks the APB phases with a three-state FSM (IDLE/SETUP/ACCESS), holds
// DEPTH 32-bit registers and counts completed transfers (saturating).
// Zero wait states: read data is fetched on the SETUP-entry edge and shown
// for the whole ACCESS cycle.
// Optional feature: define APB_SLV_PROT_CHK_EN to enable protocol-violation
// detection (sticky prot_err, cleared by err_clr). Without it prot_err is 0
// and violating sequences simply fall back to IDLE.
module apb_slave_regbank #(
    parameter int          SLV_IDX   = 0,
    parameter int          DEPTH     = 16,
    parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Pselx,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Prdata,
    output logic [15:0] xfer_cnt,
    output logic        prot_err,
    input  logic        err_clr
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          sel;
    logic [AW-1:0] idx_in;
    logic [AW-1:0] idx_l;
    logic          wr_l;
    logic [31:0]   wdata_l;
    logic [31:0]   rd_buf;
    logic [31:0]   regs [DEPTH];
    logic          setup_entry;
    logic          commit;
    logic          match;

    assign sel    = Pselx[SLV_IDX];
    // Upper address bits alias the bank; byte-lane bits are ignored.
    assign idx_in = Paddr[AW+1:2];

    // Only one select line and a slice of the address are decoded here.
    logic unused_ok;
    assign unused_ok = ^{Pselx, Paddr, err_clr};

    // Next-state decode of the APB phase tracker
    always_comb begin
        // NOTE: assigning a default first means every path drives state_nxt,
        // so no latch is inferred for the cases that do not assign it.
        state_nxt = state;
        case (state)
            IDLE:    if (sel && !Penable) state_nxt = SETUP;
            SETUP:   state_nxt = (sel && Penable) ? ACCESS : IDLE;
            ACCESS: begin
                if (!sel)         state_nxt = IDLE;
                else if (!Penable) state_nxt = SETUP;
                else               state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // SETUP is only ever entered from IDLE or ACCESS, never held.
    assign setup_entry = (state_nxt == SETUP);

`ifdef APB_SLV_PROT_CHK_EN
    logic [31:0] paddr_l;
    logic        violation;

    assign match     = (Paddr == paddr_l) && (Pwrite == wr_l);
    assign violation = (state == IDLE   &&  sel &&  Penable)
                     | (state == SETUP  && !(sel && Penable))
                     | (state == SETUP  &&  sel &&  Penable && !match)
                     | (state == ACCESS &&  sel &&  Penable);

    // Keep the full setup address so any change before ACCESS is caught
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)         paddr_l <= 32'h0;
        else if (setup_entry) paddr_l <= Paddr;
    end

    // Sticky violation flag; a new violation beats a same-cycle clear
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)       prot_err <= 1'b0;
        else if (violation) prot_err <= 1'b1;
        else if (err_clr)   prot_err <= 1'b0;
    end
`else
    assign match    = 1'b1;
    assign prot_err = 1'b0;
`endif

    assign commit = (state == SETUP) && (state_nxt == ACCESS) && match;

    // Phase state register
    always_ff @(posedge Hclk or negedge Hresetn) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (!Hresetn) state <= IDLE;
        else          state <= state_nxt;
    end

    // Latch the transfer on SETUP entry and prefetch read data
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            idx_l   <= '0;
            wr_l    <= 1'b0;
            wdata_l <= 32'h0;
            rd_buf  <= 32'h0;
        end else if (setup_entry) begin
            idx_l   <= idx_in;
            wr_l    <= Pwrite;
            wdata_l <= Pwdata;
            if (!Pwrite) rd_buf <= regs[idx_in];
        end
    end

    // Register bank: write committed on the SETUP->ACCESS edge
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            // NOTE: every register has a defined reset value, so the bank is
            // built from resettable flops rather than an unreset RAM macro.
            for (int i = 0; i < DEPTH; i++) regs[i] <= RESET_VAL;
        end else if (commit && wr_l) begin
            regs[idx_l] <= wdata_l;
        end
    end

    // Completed-transfer counter, saturating at all ones
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn)                          xfer_cnt <= 16'h0;
        else if (commit && xfer_cnt != 16'hFFFF) xfer_cnt <= xfer_cnt + 16'h1;
    end

    assign Prdata = (state == ACCESS && !wr_l) ? rd_buf : 32'h0;

endmodule
